// File: rtl/arb_pkg.sv
// Shared types and helpers for the host port round-robin arbiter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package arb_pkg;

    // Master ids are carried in a fixed-width field wide enough for the
    // largest supported master count, so the response tag type can live here
    // independently of any one arbiter's NrHosts.
    localparam int unsigned MaxHosts = 16;
    localparam int unsigned HostIdW  = (MaxHosts > 2) ? $clog2(MaxHosts) : 1;

    // Hold counter holds 0..MaxHold with MaxHold up to 15.
    localparam int unsigned HoldW    = 4;
    localparam int unsigned HoldIncW = HoldW + 1;

    // One entry of the read-response delay line.
    typedef struct packed {
        logic               valid;
        logic [HostIdW-1:0] id;
    } rsp_tag_t;

    // Next master id, wrapping to 0 after n-1.
    function automatic logic [HostIdW-1:0] wrap_inc(input logic [HostIdW-1:0] id,
                                                    input int unsigned        n);
        if (32'(id) + 32'd1 >= n) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first requester at or after
// ptr, wrapping around. Holds no state.
module rr_pick #(
    parameter int unsigned N   = 2,
    parameter int unsigned IdW = 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [IdW-1:0] ptr_i,
    output logic [IdW-1:0] sel_o,
    output logic           any_o
);

    logic           hi_hit;
    logic [IdW-1:0] hi_sel;
    logic [IdW-1:0] lo_sel;

    // Lowest requester at/above ptr wins; otherwise lowest requester below ptr.
    always_comb begin
        hi_hit = 1'b0;
        hi_sel = '0;
        lo_sel = '0;
        for (int j = int'(N) - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                if (IdW'(j) >= ptr_i) begin
                    hi_hit = 1'b1;
                    hi_sel = IdW'(j);
                end else begin
                    lo_sel = IdW'(j);
                end
            end
        end
        sel_o = hi_hit ? hi_sel : lo_sel;
        any_o = |req_i;
    end

endmodule

// File: rtl/host_arbiter.sv
// Round-robin arbiter sharing one bus host port between several masters,
// with a bounded hold for short bursts and read-response routing.
//
// Handshake: a master raises host_req_i with stable payload and keeps it until
// host_gnt_o pulses for it; a transfer happens in exactly the cycle where
// dev_req_o & dev_gnt_i are both high. Read data returns ReadLatency cycles
// after that cycle, flagged by host_rvalid_o for the issuing master only.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module host_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NrHosts      = 2,            // 2..MaxHosts
    parameter int unsigned DataWidth    = `DATA_WIDTH,
    parameter int unsigned AddressWidth = `ADDR_WIDTH,
    parameter int unsigned ReadLatency  = 1,            // 1..4
    parameter int unsigned MaxHold      = 4             // 1..15
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NrHosts-1:0]                   host_req_i,
    input  logic [NrHosts-1:0]                   host_we_i,
    input  logic [NrHosts-1:0][AddressWidth-1:0] host_addr_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i,
    output logic [NrHosts-1:0]                   host_gnt_o,
    output logic [NrHosts-1:0]                   host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o,
    output logic                                 dev_req_o,
    output logic                                 dev_we_o,
    output logic [AddressWidth-1:0]              dev_addr_o,
    output logic [DataWidth-1:0]                 dev_wdata_o,
    input  logic                                 dev_gnt_i,
    input  logic [DataWidth-1:0]                 dev_rdata_i
);

    logic [HostIdW-1:0]  ptr_q, ptr_d;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic [HostIdW-1:0]  sel;
    logic                any;
    logic [NrHosts-1:0]  sel_oh;
    logic                accept;
    logic                others;
    logic [HoldW-1:0]    hold_base;
    logic [HoldIncW-1:0] hold_inc;
    rsp_tag_t            rsp_q [ReadLatency];
    rsp_tag_t            rsp_in;
    rsp_tag_t            rsp_tail;

    rr_pick #(
        .N   (NrHosts),
        .IdW (HostIdW)
    ) u_pick (
        .req_i (host_req_i),
        .ptr_i (ptr_q),
        .sel_o (sel),
        .any_o (any)
    );

    // Forward the selected master's payload; everything is 0 when idle.
    always_comb begin
        sel_oh      = '0;
        dev_we_o    = 1'b0;
        dev_addr_o  = '0;
        dev_wdata_o = '0;
        for (int i = 0; i < int'(NrHosts); i++) begin
            if (any && sel == HostIdW'(i)) begin
                sel_oh[i]   = 1'b1;
                dev_we_o    = host_we_i[i];
                dev_addr_o  = host_addr_i[i];
                dev_wdata_o = host_wdata_i[i];
            end
        end
    end

    assign dev_req_o  = any;
    assign accept     = any & dev_gnt_i;
    assign host_gnt_o = accept ? sel_oh : '0;
    assign others     = |(host_req_i & ~sel_oh);

    // A grant to anyone other than the pointer owner starts a fresh burst.
    assign hold_base = (sel == ptr_q) ? hold_q : '0;
    assign hold_inc  = {1'b0, hold_base} + HoldIncW'(1);

    // Keep the port with the current master until its burst budget is spent
    // while someone else waits; then hand priority to the next master.
    always_comb begin
        ptr_d  = ptr_q;
        hold_d = hold_q;
        if (accept) begin
            if (hold_inc < HoldIncW'(MaxHold) || !others) begin
                ptr_d  = sel;
                hold_d = (hold_inc > HoldIncW'(MaxHold)) ? HoldW'(MaxHold)
                                                         : hold_inc[HoldW-1:0];
            end else begin
                ptr_d  = wrap_inc(sel, NrHosts);
                hold_d = '0;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            hold_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            hold_q <= hold_d;
        end
    end

    assign rsp_in = '{valid: accept & ~dev_we_o, id: sel};

    // Delay line tracking which master owns each in-flight read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(ReadLatency); i++) begin
                rsp_q[i] <= '0;
            end
        end else begin
            rsp_q[0] <= rsp_in;
            for (int i = 1; i < int'(ReadLatency); i++) begin
                rsp_q[i] <= rsp_q[i-1];
            end
        end
    end

    assign rsp_tail = rsp_q[ReadLatency-1];

    // Route the tail entry to its master; suppressed while reset is asserted
    // so a read caught by reset is never delivered.
    always_comb begin
        host_rvalid_o = '0;
        for (int i = 0; i < int'(NrHosts); i++) begin
            host_rvalid_o[i] = rsp_tail.valid && !rst_i && rsp_tail.id == HostIdW'(i);
            host_rdata_o[i]  = dev_rdata_i;
        end
    end

endmodule

// File: tb/tb_host_arbiter.sv
// Self-checking bench for host_arbiter with three masters, MaxHold=2 and
// ReadLatency=2; the bench also plays the downstream memory.
module tb_host_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int RL = 2;
    localparam int MH = 2;
    localparam int EW = 2 + DW;

    logic                      clk = 1'b0;
    logic                      rst_i;
    logic [N-1:0]              host_req_i;
    logic [N-1:0]              host_we_i;
    logic [N-1:0][AW-1:0]      host_addr_i;
    logic [N-1:0][DW-1:0]      host_wdata_i;
    logic [N-1:0]              host_gnt_o;
    logic [N-1:0]              host_rvalid_o;
    logic [N-1:0][DW-1:0]      host_rdata_o;
    logic                      dev_req_o;
    logic                      dev_we_o;
    logic [AW-1:0]             dev_addr_o;
    logic [DW-1:0]             dev_wdata_o;
    logic                      dev_gnt_i;
    logic [DW-1:0]             dev_rdata_i;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    host_arbiter #(
        .NrHosts      (N),
        .DataWidth    (DW),
        .AddressWidth (AW),
        .ReadLatency  (RL),
        .MaxHold      (MH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .host_req_i    (host_req_i),
        .host_we_i     (host_we_i),
        .host_addr_i   (host_addr_i),
        .host_wdata_i  (host_wdata_i),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .dev_req_o     (dev_req_o),
        .dev_we_o      (dev_we_o),
        .dev_addr_o    (dev_addr_o),
        .dev_wdata_o   (dev_wdata_o),
        .dev_gnt_i     (dev_gnt_i),
        .dev_rdata_i   (dev_rdata_i)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];    // {id, data} of each outstanding read
    int            due_q[$];    // cycle in which that read must return
    logic [DW-1:0] mem [int];
    logic [DW-1:0] ring_d [8];
    logic          ring_v [8];
    int            cyc;
    int            n_tests;
    int            n_fail;
    logic          chk_gnt;
    logic [N-1:0]  exp_gnt;
    logic [N-1:0]  last_gnt;
    logic [N-1:0]  pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {16'hC0DE, a};
    endfunction

    // Checks the outputs of the current cycle and updates the memory model.
    task automatic observe();
        logic [N-1:0]  g;
        logic [EW-1:0] e;
        logic [DW-1:0] rd;
        int            slot;
        g = host_gnt_o;
        if (rst_i) begin
            exp_q.delete();
            due_q.delete();
            check("rvalid_in_reset", 64'(host_rvalid_o), 64'd0);
        end else if (due_q.size() > 0 && due_q[0] == cyc) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            check("rvalid", 64'(host_rvalid_o), 64'(N'(1) << e[DW+:2]));
            check("rdata", 64'(host_rdata_o[e[DW+:2]]), 64'(e[DW-1:0]));
        end else begin
            check("rvalid_idle", 64'(host_rvalid_o), 64'd0);
        end
        last_gnt = '0;
        if (!rst_i) begin
            if (chk_gnt) check("gnt", 64'(g), 64'(exp_gnt));
            check("gnt_any", 64'(|g), 64'((|host_req_i) & dev_gnt_i));
            check("gnt_onehot_req", 64'($onehot0(g) && ((g & ~host_req_i) == '0)), 64'd1);
            if (host_req_i == '0)
                check("dev_idle", 64'({dev_req_o, dev_we_o, dev_addr_o, dev_wdata_o}), 64'd0);
            else
                check("dev_req", 64'(dev_req_o), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    check("dev_addr", 64'(dev_addr_o), 64'(host_addr_i[i]));
                    check("dev_we", 64'(dev_we_o), 64'(host_we_i[i]));
                    if (host_we_i[i]) begin
                        check("dev_wdata", 64'(dev_wdata_o), 64'(host_wdata_i[i]));
                        mem[int'(host_addr_i[i])] = host_wdata_i[i];
                    end else begin
                        rd   = mem_rd(host_addr_i[i]);
                        slot = (cyc + RL) % 8;
                        exp_q.push_back({2'(i), rd});
                        due_q.push_back(cyc + RL);
                        ring_d[slot] = rd;
                        ring_v[slot] = 1'b1;
                    end
                end
            end
            last_gnt = g;
        end
    endtask

    // One clock cycle: inputs already driven, downstream read data applied.
    task automatic tick();
        int s;
        s = cyc % 8;
        dev_rdata_i = ring_v[s] ? ring_d[s] : DW'($urandom);
        ring_v[s] = 1'b0;
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic new_payloads();
        for (int i = 0; i < N; i++) begin
            if (last_gnt[i]) begin
                host_addr_i[i]  = AW'($urandom_range(0, 15));
                host_wdata_i[i] = DW'($urandom);
                pend[i]         = 1'b0;
            end
        end
    endtask

    task automatic drive_cycle(input logic [N-1:0] req, input logic [N-1:0] we,
                               input logic [N-1:0] gnt_exp);
        host_req_i = req;
        host_we_i  = we;
        chk_gnt    = 1'b1;
        exp_gnt    = gnt_exp;
        tick();
        chk_gnt    = 1'b0;
        new_payloads();
    endtask

    // seq packs one expected master id per cycle, 2 bits each, LSB first.
    task automatic run_seq(input logic [N-1:0] req, input logic [N-1:0] we,
                           input int n, input logic [31:0] seq);
        for (int k = 0; k < n; k++) begin
            drive_cycle(req, we, N'(1) << seq[2*k +: 2]);
        end
    endtask

    task automatic idle(input int n);
        host_req_i = '0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        host_req_i = '0;
        rst_i      = 1'b1;
        tick();
        rst_i      = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests      = 0;
        n_fail       = 0;
        cyc          = 0;
        chk_gnt      = 1'b0;
        exp_gnt      = '0;
        last_gnt     = '0;
        pend         = '0;
        rst_i        = 1'b1;
        host_req_i   = '0;
        host_we_i    = '0;
        host_addr_i  = '0;
        host_wdata_i = '0;
        dev_gnt_i    = 1'b1;
        dev_rdata_i  = '0;
        for (int i = 0; i < 8; i++) begin
            ring_v[i] = 1'b0;
            ring_d[i] = '0;
        end
        mem[16'h0100] = 32'hDEADBEEF;

        @(posedge clk);
        #1;
        do_reset();
        do_reset();

        // Reset state: no grant, no response, idle downstream.
        drive_cycle('0, '0, '0);

        // Single master read of 0x100 from host 1.
        host_addr_i[1] = 16'h0100;
        drive_cycle(3'b010, 3'b000, 3'b010);
        idle(3);

        // Hosts 0 and 1 contend: 0,0,1,1,0,0,1,1.
        do_reset();
        run_seq(3'b011, 3'b000, 8, 32'h0000_5050);
        idle(3);

        // Host 0 idle, hosts 1 and 2 contend: 1,1,2,2,1,1,2,2.
        do_reset();
        run_seq(3'b110, 3'b000, 8, 32'h0000_A5A5);
        idle(3);

        // All hosts contend: 0,0,1,1,2,2 repeated.
        do_reset();
        run_seq(3'b111, 3'b000, 12, 32'h00A5_0A50);
        idle(3);

        // Host 0 writes 0x55 to 0x200 while host 1 reads 0x200.
        do_reset();
        host_addr_i[0]  = 16'h0200;
        host_wdata_i[0] = 32'h0000_0055;
        host_addr_i[1]  = 16'h0200;
        drive_cycle(3'b011, 3'b001, 3'b001);
        drive_cycle(3'b010, 3'b000, 3'b010);
        idle(3);

        // Downstream stall for three cycles with host 1 requesting.
        do_reset();
        host_addr_i[1] = 16'h0300;
        dev_gnt_i      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(3'b010, 3'b000, 3'b000);
            check("stall_addr", 64'(dev_addr_o), 64'h0300);
            check("stall_req", 64'(dev_req_o), 64'd1);
        end
        dev_gnt_i = 1'b1;
        drive_cycle(3'b010, 3'b000, 3'b010);
        idle(3);

        // Reset one cycle after a read grant: nothing returns, pointer clears.
        do_reset();
        host_addr_i[1] = 16'h0040;
        drive_cycle(3'b010, 3'b000, 3'b010);
        do_reset();
        idle(4);
        drive_cycle(3'b111, 3'b000, 3'b001);
        idle(3);

        // Random traffic with random downstream stalls.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]      = 1'b1;
                    host_we_i[i] = 1'($urandom_range(0, 1));
                end
            end
            host_req_i = pend;
            dev_gnt_i  = ($urandom_range(0, 3) != 0);
            tick();
            new_payloads();
        end
        dev_gnt_i = 1'b1;
        idle(RL + 2);
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
